// File: rtl/bcd_score_sequencer.sv
// Multi-digit packed BCD score accumulator: one shared 4-bit BCD adder walks the
// digits LSD first, and the result is committed atomically, saturating at all-nines.

module bcd_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] raw;
    logic [4:0] adj;

    always_comb begin
        raw  = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        adj  = raw - 5'd10;
        cout = (raw > 5'd9);
        sum  = cout ? adj[3:0] : raw[3:0];
    end
endmodule

module bcd_score_sequencer #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                add_req,
    input  logic [3:0]          add_val,
    output logic                add_ready,
    output logic                busy,
    output logic                add_done,
    output logic [4*DIGITS-1:0] score,
    output logic                overflow
);
    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = $clog2(DIGITS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Handshake: an increment transfers on a rising edge where add_req && add_ready.
    // add_ready is only high in IDLE with clear low; the requester holds add_req until then.
    state_t           state;
    state_t           state_next;
    logic [W-1:0]     work;
    logic [W-1:0]     work_upd;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [3:0]       operand;
    logic [3:0]       digit_a;
    logic [3:0]       digit_b;
    logic [3:0]       digit_sum;
    logic             digit_cout;
    logic             last_digit;

    bcd_adder u_adder (
        .a    (digit_a),
        .b    (digit_b),
        .cin  (carry),
        .sum  (digit_sum),
        .cout (digit_cout)
    );

    always_comb begin
        last_digit = (idx == IDX_W'(DIGITS - 1));
        digit_a    = work[4*idx +: 4];
        digit_b    = (idx == '0) ? operand : 4'd0;
        work_upd   = work;
        work_upd[4*idx +: 4] = digit_sum;
    end

    always_comb begin
        state_next = state;
        add_ready  = (state == IDLE) && !clear;
        busy       = (state == ADD) || (state == DONE);
        add_done   = (state == DONE) && !clear;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (add_req) state_next = ADD;
                ADD:     if (last_digit) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            score    <= '0;
            overflow <= 1'b0;
            work     <= '0;
            idx      <= '0;
            carry    <= 1'b0;
            operand  <= 4'd0;
        end else begin
            state <= state_next;
            if (clear) begin
                score    <= '0;
                overflow <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (add_req) begin
                            operand <= (add_val > 4'd9) ? 4'd9 : add_val;
                            work    <= score;
                            idx     <= '0;
                            carry   <= 1'b0;
                        end
                    end
                    ADD: begin
                        work  <= work_upd;
                        carry <= digit_cout;
                        idx   <= idx + IDX_W'(1);
                        // A carry out of the MSD means the true sum cannot be shown: pin to all-nines.
                        if (last_digit) begin
                            if (digit_cout) begin
                                score    <= {DIGITS{4'h9}};
                                overflow <= 1'b1;
                            end else begin
                                score <= work_upd;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bcd_score_sequencer.sv
// Bench for bcd_score_sequencer: directed scenarios plus random adds, checked against
// an integer-valued score model converted to packed BCD.

module tb_bcd_score_sequencer;
    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
    localparam int MAXV   = 9999;

    logic         clk = 1'b0;
    logic         reset;
    logic         clear;
    logic         add_req;
    logic [3:0]   add_val;
    logic         add_ready;
    logic         busy;
    logic         add_done;
    logic [W-1:0] score;
    logic         overflow;

    int   passed = 0;
    int   total  = 0;
    int   model  = 0;
    logic model_ovf = 1'b0;

    bcd_score_sequencer #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .add_req   (add_req),
        .add_val   (add_val),
        .add_ready (add_ready),
        .busy      (busy),
        .add_done  (add_done),
        .score     (score),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int           t;
        r = '0;
        t = v;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction with per-cycle latency checks; updates the model.
    task automatic do_add(input logic [3:0] val);
        int n;
        int inc;
        logic [W-1:0] old_score;
        n = 0;
        while (!add_ready && n < 20) begin
            step();
            n++;
        end
        total++;
        if (!add_ready) begin
            $display("FAIL add_ready_wait got=%0b exp=1", add_ready);
            return;
        end
        passed++;
        old_score = to_bcd(model);
        add_req = 1'b1;
        add_val = val;
        step();
        add_req = 1'b0;
        add_val = 4'($urandom_range(0, 15));
        for (int k = 1; k <= DIGITS; k++) begin
            total++;
            if (busy !== 1'b1 || add_done !== 1'b0 || score !== old_score) begin
                $display("FAIL add_busy_phase cyc=%0d busy=%0b done=%0b score=%h exp busy=1 done=0 score=%h",
                         k, busy, add_done, score, old_score);
            end else passed++;
            step();
        end
        inc = (val > 9) ? 9 : int'(val);
        if (model + inc > MAXV) begin
            model     = MAXV;
            model_ovf = 1'b1;
        end else begin
            model = model + inc;
        end
        total++;
        if (add_done !== 1'b1 || busy !== 1'b1 || score !== to_bcd(model) || overflow !== model_ovf) begin
            $display("FAIL add_commit done=%0b busy=%0b score=%h ovf=%0b exp done=1 busy=1 score=%h ovf=%0b",
                     add_done, busy, score, overflow, to_bcd(model), model_ovf);
        end else passed++;
        step();
        total++;
        if (add_ready !== 1'b1 || add_done !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL add_return rdy=%0b done=%0b busy=%0b exp rdy=1 done=0 busy=0",
                     add_ready, add_done, busy);
        end else passed++;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        model     = 0;
        model_ovf = 1'b0;
    endtask

    task automatic reach(input int target);
        while (model < target) begin
            do_add(4'((target - model > 9) ? 9 : target - model));
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        clear   = 1'b0;
        add_req = 1'b0;
        add_val = 4'd0;
        step();
        step();
        total++;
        if (score !== '0 || overflow !== 1'b0 || add_done !== 1'b0 || busy !== 1'b0 || add_ready !== 1'b1) begin
            $display("FAIL reset_state score=%h ovf=%0b done=%0b busy=%0b rdy=%0b exp 0000/0/0/0/1",
                     score, overflow, add_done, busy, add_ready);
        end else passed++;
        reset = 1'b0;
        step();
        model     = 0;
        model_ovf = 1'b0;
    endtask

    task automatic test_single_add();
        do_add(4'd7);
        total++;
        if (score !== 16'h0007) begin
            $display("FAIL single_add score=%h exp=0007", score);
        end else passed++;
    endtask

    task automatic test_ripple();
        do_clear();
        reach(999);
        do_add(4'd1);
        total++;
        if (score !== 16'h1000 || overflow !== 1'b0) begin
            $display("FAIL ripple score=%h ovf=%0b exp=1000/0", score, overflow);
        end else passed++;
        do_clear();
        reach(995);
        do_add(4'hC);
        total++;
        if (score !== 16'h1004) begin
            $display("FAIL clamp score=%h exp=1004", score);
        end else passed++;
    endtask

    task automatic test_saturate();
        do_clear();
        reach(9998);
        do_add(4'd5);
        total++;
        if (score !== 16'h9999 || overflow !== 1'b1) begin
            $display("FAIL saturate score=%h ovf=%0b exp=9999/1", score, overflow);
        end else passed++;
        do_add(4'd3);
        total++;
        if (score !== 16'h9999 || overflow !== 1'b1) begin
            $display("FAIL saturate_hold score=%h ovf=%0b exp=9999/1", score, overflow);
        end else passed++;
    endtask

    task automatic test_clear_abort();
        int dones;
        do_clear();
        reach(123);
        add_req = 1'b1;
        add_val = 4'd4;
        step();
        add_req = 1'b0;
        step();
        clear = 1'b1;
        #1;
        total++;
        if (add_done !== 1'b0 || add_ready !== 1'b0) begin
            $display("FAIL clear_mid done=%0b rdy=%0b exp 0/0", add_done, add_ready);
        end else passed++;
        step();
        clear = 1'b0;
        model = 0;
        model_ovf = 1'b0;
        #1;
        total++;
        if (score !== '0 || overflow !== 1'b0 || busy !== 1'b0 || add_ready !== 1'b1 || add_done !== 1'b0) begin
            $display("FAIL clear_abort score=%h ovf=%0b busy=%0b rdy=%0b done=%0b exp 0000/0/0/1/0",
                     score, overflow, busy, add_ready, add_done);
        end else passed++;
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            if (add_done) dones++;
            step();
        end
        total++;
        if (dones !== 0 || score !== '0) begin
            $display("FAIL clear_no_done dones=%0d score=%h exp 0/0000", dones, score);
        end else passed++;
        clear   = 1'b1;
        add_req = 1'b1;
        add_val = 4'd5;
        #1;
        total++;
        if (add_ready !== 1'b0) begin
            $display("FAIL clear_vs_req rdy=%0b exp=0", add_ready);
        end else passed++;
        step();
        clear   = 1'b0;
        add_req = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || score !== '0) begin
            $display("FAIL clear_vs_req_idle busy=%0b score=%h exp 0/0000", busy, score);
        end else passed++;
    endtask

    task automatic test_back_to_back();
        int dones;
        int last_k;
        do_clear();
        dones  = 0;
        last_k = -1;
        add_req = 1'b1;
        add_val = 4'd1;
        for (int k = 0; k < 18; k++) begin
            if (add_done) begin
                dones++;
                model = model + 1;
                total++;
                if (score !== to_bcd(model) || (last_k >= 0 && k - last_k != DIGITS + 2)) begin
                    $display("FAIL b2b_commit k=%0d score=%h gap=%0d exp score=%h gap=%0d",
                             k, score, k - last_k, to_bcd(model), DIGITS + 2);
                end else passed++;
                last_k = k;
            end
            if (k == 17) add_req = 1'b0;
            step();
        end
        total++;
        if (dones !== 3 || score !== 16'h0003) begin
            $display("FAIL b2b_count dones=%0d score=%h exp 3/0003", dones, score);
        end else passed++;
    endtask

    task automatic test_random();
        do_clear();
        for (int i = 0; i < 40; i++) begin
            do_add(4'($urandom_range(0, 15)));
        end
        total++;
        if (score !== to_bcd(model) || overflow !== model_ovf) begin
            $display("FAIL random_final score=%h ovf=%0b exp %h/%0b", score, overflow, to_bcd(model), model_ovf);
        end else passed++;
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_ripple();
        test_saturate();
        test_clear_abort();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
